// File: rtl/airi5c_dtm_v2.sv
// airi5c_dtm_v2: RISC-V JTAG debug transport module, fully clocked on clk.
// Optional feature macro: AIRI5C_DTM_HARDRESET_EN (dtmcs.dmihardreset support).
`default_nettype none

module airi5c_dtm_v2 #(
    parameter int          IR_LEN      = 5,
    parameter int          ABITS       = 7,
    parameter logic [31:0] IDCODE_VAL  = 32'h1000_1001,
    parameter int          SYNC_STAGES = 2,
    parameter int          IDLE_HINT   = 1
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             tck,
    input  logic             tms,
    input  logic             tdi,
    output logic             tdo,
    output logic [ABITS-1:0] dmi_addr,
    output logic [31:0]      dmi_wdata,
    output logic             dmi_wen,
    output logic             dmi_req,
    input  logic             dmi_ack,
    input  logic [31:0]      dmi_rdata,
    input  logic             dmi_error
);

    localparam int         DRW         = ABITS + 34;
    localparam int         DLW         = $clog2(DRW);
    localparam logic [2:0] c_idle_hint = 3'(IDLE_HINT);
    localparam logic [5:0] c_abits     = 6'(ABITS);

    typedef enum logic [3:0] {
        S_TLR, S_RTI, S_SEL_DR, S_CAP_DR, S_SHIFT_DR, S_EXIT1_DR, S_PAUSE_DR, S_EXIT2_DR,
        S_UPD_DR, S_SEL_IR, S_CAP_IR, S_SHIFT_IR, S_EXIT1_IR, S_PAUSE_IR, S_EXIT2_IR, S_UPD_IR
    } tap_state_t;

    tap_state_t              r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0]  r_tck_s, r_tms_s, r_tdi_s;
    logic [IR_LEN-1:0]       r_ir, r_ir_sh;
    logic [DRW-1:0]          r_dr, w_dr_cap, w_dr_shift;
    logic [DLW-1:0]          w_dr_msb;
    logic [1:0]              r_dmistat, w_op_cap;
    logic [31:0]             r_rdata;
    logic                    w_tck_rise, w_tck_fall, w_tms, w_tdi;
    logic                    w_sel_idcode, w_sel_dtmcs, w_sel_dmi, w_upd_dr;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_tck_s <= '0;
            r_tms_s <= '0;
            r_tdi_s <= '0;
        end else begin
            r_tck_s <= {r_tck_s[SYNC_STAGES-2:0], tck};
            r_tms_s <= {r_tms_s[SYNC_STAGES-2:0], tms};
            r_tdi_s <= {r_tdi_s[SYNC_STAGES-2:0], tdi};
        end
    end

    // tms/tdi are taken from the stage aligned with the older tck sample,
    // i.e. their value just before the tck edge.
    assign w_tck_rise = r_tck_s[SYNC_STAGES-2] & ~r_tck_s[SYNC_STAGES-1];
    assign w_tck_fall = ~r_tck_s[SYNC_STAGES-2] & r_tck_s[SYNC_STAGES-1];
    assign w_tms      = r_tms_s[SYNC_STAGES-1];
    assign w_tdi      = r_tdi_s[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)         r_state <= S_TLR;
        else if (w_tck_rise) r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_TLR:      w_state_nxt = w_tms ? S_TLR      : S_RTI;
            S_RTI:      w_state_nxt = w_tms ? S_SEL_DR   : S_RTI;
            S_SEL_DR:   w_state_nxt = w_tms ? S_SEL_IR   : S_CAP_DR;
            S_CAP_DR:   w_state_nxt = w_tms ? S_EXIT1_DR : S_SHIFT_DR;
            S_SHIFT_DR: w_state_nxt = w_tms ? S_EXIT1_DR : S_SHIFT_DR;
            S_EXIT1_DR: w_state_nxt = w_tms ? S_UPD_DR   : S_PAUSE_DR;
            S_PAUSE_DR: w_state_nxt = w_tms ? S_EXIT2_DR : S_PAUSE_DR;
            S_EXIT2_DR: w_state_nxt = w_tms ? S_UPD_DR   : S_SHIFT_DR;
            S_UPD_DR:   w_state_nxt = w_tms ? S_SEL_DR   : S_RTI;
            S_SEL_IR:   w_state_nxt = w_tms ? S_TLR      : S_CAP_IR;
            S_CAP_IR:   w_state_nxt = w_tms ? S_EXIT1_IR : S_SHIFT_IR;
            S_SHIFT_IR: w_state_nxt = w_tms ? S_EXIT1_IR : S_SHIFT_IR;
            S_EXIT1_IR: w_state_nxt = w_tms ? S_UPD_IR   : S_PAUSE_IR;
            S_PAUSE_IR: w_state_nxt = w_tms ? S_EXIT2_IR : S_PAUSE_IR;
            S_EXIT2_IR: w_state_nxt = w_tms ? S_UPD_IR   : S_SHIFT_IR;
            S_UPD_IR:   w_state_nxt = w_tms ? S_SEL_DR   : S_RTI;
            default:    w_state_nxt = S_TLR;
        endcase
    end

    assign w_sel_idcode = (r_ir == IR_LEN'(8'h01));
    assign w_sel_dtmcs  = (r_ir == IR_LEN'(8'h10));
    assign w_sel_dmi    = (r_ir == IR_LEN'(8'h11));
    assign w_op_cap     = dmi_req ? 2'd3 : r_dmistat;
    assign w_upd_dr     = w_tck_fall && (r_state == S_UPD_DR);

    always_comb begin
        w_dr_cap = '0;
        w_dr_msb = '0;
        if (w_sel_dmi) begin
            w_dr_cap = {dmi_addr, r_rdata, w_op_cap};
            w_dr_msb = DLW'(DRW - 1);
        end else if (w_sel_dtmcs) begin
            w_dr_cap = DRW'({17'd0, c_idle_hint, r_dmistat, c_abits, 4'd1});
            w_dr_msb = DLW'(31);
        end else if (w_sel_idcode) begin
            w_dr_cap = DRW'({IDCODE_VAL[31:1], 1'b1});
            w_dr_msb = DLW'(31);
        end
        // tdi enters at the top of the selected register's active length
        w_dr_shift           = r_dr >> 1;
        w_dr_shift[w_dr_msb] = w_tdi;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_ir    <= IR_LEN'(1);
            r_ir_sh <= '0;
            r_dr    <= '0;
            tdo     <= 1'b0;
        end else begin
            if (w_tck_rise) begin
                case (r_state)
                    S_CAP_IR:   r_ir_sh <= IR_LEN'(2'b01);
                    S_SHIFT_IR: r_ir_sh <= {w_tdi, r_ir_sh[IR_LEN-1:1]};
                    S_CAP_DR:   r_dr    <= w_dr_cap;
                    S_SHIFT_DR: r_dr    <= w_dr_shift;
                    default:    ;
                endcase
            end
            if (w_tck_fall) begin
                if (r_state == S_SHIFT_IR)      tdo <= r_ir_sh[0];
                else if (r_state == S_SHIFT_DR) tdo <= r_dr[0];
                if (r_state == S_UPD_IR)        r_ir <= r_ir_sh;
            end
            if (r_state == S_TLR) r_ir <= IR_LEN'(1);
        end
    end

`ifdef AIRI5C_DTM_HARDRESET_EN
    logic w_hardreset;
    assign w_hardreset = w_upd_dr && w_sel_dtmcs && r_dr[17];
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            dmi_req   <= 1'b0;
            dmi_wen   <= 1'b0;
            dmi_addr  <= '0;
            dmi_wdata <= '0;
            r_rdata   <= '0;
            r_dmistat <= 2'd0;
        end else begin
            if (dmi_req && dmi_ack) begin
                r_rdata <= dmi_rdata;
                dmi_req <= 1'b0;
                if (dmi_error && r_dmistat == 2'd0) r_dmistat <= 2'd2;
            end
            if (w_upd_dr && w_sel_dmi) begin
                if (dmi_req) begin
                    if (r_dmistat == 2'd0) r_dmistat <= 2'd3;
                end else if (r_dmistat == 2'd0 && (r_dr[1:0] == 2'd1 || r_dr[1:0] == 2'd2)) begin
                    dmi_addr  <= r_dr[DRW-1:34];
                    dmi_wdata <= r_dr[33:2];
                    dmi_wen   <= r_dr[1];
                    dmi_req   <= 1'b1;
                end
            end
            if (w_upd_dr && w_sel_dtmcs && r_dr[16]) r_dmistat <= 2'd0;
`ifdef AIRI5C_DTM_HARDRESET_EN
            // Later assignments override a same-cycle acknowledge.
            if (w_hardreset) begin
                dmi_req   <= 1'b0;
                r_rdata   <= r_rdata;
                r_dmistat <= 2'd0;
            end
`endif
            if (r_state == S_TLR) r_dmistat <= 2'd0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_airi5c_dtm_v2.sv
// tb_airi5c_dtm_v2: directed JTAG/DMI scans with hand-computed expectations.
`default_nettype none

module tb_airi5c_dtm_v2;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        tck = 1'b0, tms = 1'b1, tdi = 1'b0;
    logic        tdo;
    logic [6:0]  dmi_addr;
    logic [31:0] dmi_wdata;
    logic        dmi_wen, dmi_req;
    logic        dmi_ack = 1'b0;
    logic [31:0] dmi_rdata = '0;
    logic        dmi_error = 1'b0;

    int total = 0;
    int bad   = 0;
    logic [63:0] dout;

    airi5c_dtm_v2 #(
        .IR_LEN(5), .ABITS(7), .IDCODE_VAL(32'h1000_1001), .SYNC_STAGES(2), .IDLE_HINT(1)
    ) dut (
        .clk(clk), .nreset(nreset), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo),
        .dmi_addr(dmi_addr), .dmi_wdata(dmi_wdata), .dmi_wen(dmi_wen), .dmi_req(dmi_req),
        .dmi_ack(dmi_ack), .dmi_rdata(dmi_rdata), .dmi_error(dmi_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tck_cyc(input logic tms_v, input logic tdi_v);
        @(negedge clk);
        tms = tms_v;
        tdi = tdi_v;
        repeat (4) @(negedge clk);
        tck = 1'b1;
        repeat (6) @(negedge clk);
        tck = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic reset_tap();
        repeat (5) tck_cyc(1'b1, 1'b0);
        tck_cyc(1'b0, 1'b0);
    endtask

    // From Run-Test/Idle through a full shift back to Run-Test/Idle.
    task automatic scan(input logic ir, input int n, input logic [63:0] din, output logic [63:0] d_o);
        d_o = '0;
        tck_cyc(1'b1, 1'b0);
        if (ir) tck_cyc(1'b1, 1'b0);
        tck_cyc(1'b0, 1'b0);
        tck_cyc(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            d_o[i] = tdo;
            tck_cyc(i == n - 1, din[i]);
        end
        tck_cyc(1'b1, 1'b0);
        tck_cyc(1'b0, 1'b0);
    endtask

    function automatic logic [63:0] dmiw(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        return {23'd0, a, d, op};
    endfunction

    task automatic ack(input logic [31:0] rd, input logic err);
        repeat (5) @(negedge clk);
        dmi_rdata = rd;
        dmi_error = err;
        dmi_ack   = 1'b1;
        @(negedge clk);
        dmi_ack   = 1'b0;
        dmi_error = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tdo", 64'(tdo), 64'd0);
        chk("rst_req", 64'(dmi_req), 64'd0);
        chk("rst_dmi_out", {dmi_addr, dmi_wdata, dmi_wen}, 64'd0);
        nreset = 1'b1;
        reset_tap();

        // IDCODE preselected by reset, then via explicit IR scan
        scan(1'b0, 32, 64'd0, dout);
        chk("idcode_after_reset", dout, 64'h1000_1001);
        scan(1'b1, 5, 64'h01, dout);
        chk("ir_capture", dout, 64'h01);
        scan(1'b0, 32, 64'd0, dout);
        chk("idcode", dout, 64'h1000_1001);

        scan(1'b1, 5, 64'h10, dout);
        scan(1'b0, 32, 64'd0, dout);
        chk("dtmcs", dout, 64'h1071);

        scan(1'b1, 5, 64'h1F, dout);
        scan(1'b0, 2, 64'h3, dout);
        chk("bypass", dout, 64'h2);

        // DMI write, acked
        scan(1'b1, 5, 64'h11, dout);
        scan(1'b0, 41, dmiw(7'h10, 32'h1, 2'd2), dout);
        chk("wr_req_outs", {dmi_req, dmi_wen, dmi_addr, dmi_wdata}, {55'h3, 7'h10, 32'h1} >> 0);
        ack(32'h1234_5678, 1'b0);
        chk("wr_req_drop", 64'(dmi_req), 64'd0);
        scan(1'b0, 41, dmiw(7'h0, 32'h0, 2'd0), dout);
        chk("wr_capture", dout, dmiw(7'h10, 32'h1234_5678, 2'd0));

        // Read with busy overrun
        scan(1'b0, 41, dmiw(7'h11, 32'h0, 2'd1), dout);
        chk("rd_req", {dmi_req, dmi_wen, dmi_addr}, {55'd0, 1'b1, 1'b0, 7'h11});
        scan(1'b0, 41, dmiw(7'h22, 32'h0, 2'd1), dout);
        chk("busy_capture", dout, dmiw(7'h11, 32'h1234_5678, 2'd3));
        chk("busy_no_new", {dmi_req, dmi_addr}, {56'd1, 7'h11} >> 0);
        ack(32'hDEAD_BEEF, 1'b0);
        chk("rd_req_drop", 64'(dmi_req), 64'd0);
        scan(1'b0, 41, dmiw(7'h0, 32'h0, 2'd0), dout);
        chk("rd_data_busy", dout, dmiw(7'h11, 32'hDEAD_BEEF, 2'd3));
        scan(1'b1, 5, 64'h10, dout);
        scan(1'b0, 32, 64'h1_0000, dout);
        chk("dtmcs_busy", dout, 64'h1C71);
        scan(1'b1, 5, 64'h11, dout);
        scan(1'b0, 41, dmiw(7'h0, 32'h0, 2'd0), dout);
        chk("busy_cleared", dout, dmiw(7'h11, 32'hDEAD_BEEF, 2'd0));

        // Read failing with error; sticky status blocks new requests
        scan(1'b0, 41, dmiw(7'h05, 32'h0, 2'd1), dout);
        chk("err_rd_req", 64'(dmi_req), 64'd1);
        ack(32'h0000_0BAD, 1'b1);
        scan(1'b0, 41, dmiw(7'h06, 32'h0, 2'd1), dout);
        chk("err_capture", dout, dmiw(7'h05, 32'h0000_0BAD, 2'd2));
        chk("err_blocks_req", 64'(dmi_req), 64'd0);
        scan(1'b0, 41, dmiw(7'h0, 32'h0, 2'd0), dout);
        chk("err_sticky", dout, dmiw(7'h05, 32'h0000_0BAD, 2'd2));
        scan(1'b1, 5, 64'h10, dout);
        scan(1'b0, 32, 64'h1_0000, dout);
        chk("dtmcs_err", dout, 64'h1871);
        scan(1'b1, 5, 64'h11, dout);
        scan(1'b0, 41, dmiw(7'h0, 32'h0, 2'd0), dout);
        chk("err_cleared", dout, dmiw(7'h05, 32'h0000_0BAD, 2'd0));

        // Test-Logic-Reset keeps a pending request and reselects IDCODE
        scan(1'b0, 41, dmiw(7'h07, 32'h0, 2'd1), dout);
        reset_tap();
        chk("tlr_keeps_req", {dmi_req, dmi_addr}, {56'd1, 7'h07} >> 0);
        scan(1'b0, 32, 64'd0, dout);
        chk("tlr_idcode", dout, 64'h1000_1001);
        ack(32'h0000_55AA, 1'b0);
        chk("tlr_ack_drop", 64'(dmi_req), 64'd0);

        // Async reset drops a pending request; late ack ignored
        scan(1'b1, 5, 64'h11, dout);
        scan(1'b0, 41, dmiw(7'h08, 32'h0, 2'd1), dout);
        chk("pre_rst_req", 64'(dmi_req), 64'd1);
        #2 nreset = 1'b0;
        #1 chk("async_rst", {dmi_req, dmi_addr, tdo}, 64'd0);
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        ack(32'hFFFF_FFFF, 1'b0);
        chk("late_ack_req", 64'(dmi_req), 64'd0);
        reset_tap();
        scan(1'b1, 5, 64'h11, dout);
        scan(1'b0, 41, dmiw(7'h0, 32'h0, 2'd0), dout);
        chk("late_ack_data", dout, dmiw(7'h0, 32'h0, 2'd0));

`ifdef AIRI5C_DTM_HARDRESET_EN
        scan(1'b0, 41, dmiw(7'h09, 32'h0, 2'd1), dout);
        chk("hr_req", 64'(dmi_req), 64'd1);
        scan(1'b1, 5, 64'h10, dout);
        scan(1'b0, 32, 64'h2_0000, dout);
        chk("hr_drop", 64'(dmi_req), 64'd0);
        ack(32'hCAFE_F00D, 1'b1);
        scan(1'b1, 5, 64'h11, dout);
        scan(1'b0, 41, dmiw(7'h0, 32'h0, 2'd0), dout);
        chk("hr_capture", dout, dmiw(7'h09, 32'h0, 2'd0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/airi5c_dtm_v2.md
AIRI5C_DTM_V2 -- requirements
Module: airi5c_dtm_v2

Interface
REQ-001 Parameter IR_LEN, default 5, instruction register width (min 5).
REQ-002 Parameter ABITS, default 7, DMI address width (7..16).
REQ-003 Parameter IDCODE_VAL, default 32'h1000_1001, value captured by IDCODE; bit 0 SHALL read 1.
REQ-004 Parameter SYNC_STAGES, default 2, tck/tms/tdi synchroniser depth (2..4).
REQ-005 Parameter IDLE_HINT, default 1, value reported in dtmcs.idle[14:12].
REQ-006 clk  input  1  system clock; all state clocked on its rising edge.
REQ-007 nreset  input  1  reset, asynchronous, active-low.
REQ-008 tck, tms, tdi  input  1 each  JTAG pins, asynchronous to clk.
REQ-009 tdo  output  1  JTAG data out, registered.
REQ-010 dmi_addr  output  ABITS  request address, stable while dmi_req=1.
REQ-011 dmi_wdata  output  32  write data, stable while dmi_req=1.
REQ-012 dmi_wen  output  1  1=write, 0=read, stable while dmi_req=1.
REQ-013 dmi_req  output  1  level request, held until acknowledged.
REQ-014 dmi_ack  input  1  one-cycle completion pulse, ignored while dmi_req=0.
REQ-015 dmi_rdata  input  32  read data, valid with dmi_ack.
REQ-016 dmi_error  input  1  failure flag, valid with dmi_ack.

Function
REQ-017 tck, tms and tdi SHALL pass through SYNC_STAGES flops; a tck rising or falling event SHALL be a one-clk pulse derived from the last two tck stages.
REQ-018 The TAP FSM SHALL implement all 16 IEEE 1149.1 states and advance only on tck rising events.
REQ-019 Capture-IR SHALL load {0..0,2'b01}; Shift-IR SHALL shift LSB-first; Update-IR (on tck falling) SHALL load IR.
REQ-020 Test-Logic-Reset SHALL set IR=1 (IDCODE) and clear sticky dmistat; it SHALL NOT abort a pending request.
REQ-021 IR decode: 0x01 IDCODE(32), 0x10 DTMCS(32), 0x11 DMI(ABITS+34); every other code selects BYPASS(1), which captures 0.
REQ-022 DTMCS capture value: [3:0]=1 (version), [9:4]=ABITS, [11:10]=dmistat, [14:12]=IDLE_HINT, all other bits 0.
REQ-023 DMI capture value: {latched addr, latched rdata, op}; op=3 if dmi_req=1, else op=dmistat.
REQ-024 Update-DR on DMI with op 1 (read) or 2 (write), dmistat=0 and dmi_req=0 SHALL drive addr/wdata/wen and assert dmi_req on the clk edge after the tck falling event.
REQ-025 Update-DR on DMI while dmi_req=1 SHALL set dmistat=3 and issue nothing; with dmistat!=0, or with op 0 or 3, nothing SHALL be issued.
REQ-026 On dmi_ack with dmi_req=1: latch dmi_rdata; deassert dmi_req next edge; if dmi_error=1, set dmistat=2 unless already nonzero.
REQ-027 Update-DR on DTMCS with bit 16 (dmireset)=1 SHALL clear dmistat to 0.
REQ-028 tdo SHALL update on tck falling events with the LSB of the selected shift register (IR in Shift-IR), and hold otherwise.
REQ-029 dmistat SHALL be sticky: 0 ok, 2 failed, 3 busy; 1 SHALL never be produced.

Reset
REQ-030 nreset low SHALL immediately force: state=Test-Logic-Reset, IR=1, all shift registers 0, dmistat=0, tdo=0, dmi_req=0, dmi_wen=0, dmi_addr=0, dmi_wdata=0, latched rdata=0.
REQ-031 Reset asserted with dmi_req=1 SHALL drop the request; a dmi_ack after release SHALL be ignored.

Configuration
REQ-032 Macro AIRI5C_DTM_HARDRESET_EN defined: DTMCS bit 17 (dmihardreset)=1 in Update-DR SHALL drop dmi_req next edge, discard any pending response and clear dmistat; a dmi_ack in that same cycle SHALL be discarded.
REQ-033 Macro undefined: bit 17 SHALL be ignored and no hardreset logic compiled.

Verification
REQ-034 Scan IR=0x01, shift DR 32 bits -> tdo yields IDCODE_VAL LSB-first (0x10001001 at default).
REQ-035 Scan DTMCS, ABITS=7 -> 0x00001071 read out.
REQ-036 DMI write addr 0x10 data 0x00000001 op 2 -> dmi_req=1, dmi_wen=1, dmi_addr=0x10, dmi_wdata=0x1; ack after 5 clk -> dmi_req=0 next edge; next capture op=0.
REQ-037 DMI read addr 0x11, ack withheld, second Update-DR -> dmistat=3, no new request; ack with rdata 0xDEADBEEF, DMI scan -> data 0xDEADBEEF, op=3; dmireset -> op=0.
REQ-038 Read acked with dmi_error=1 -> dmistat=2; later busy overrun keeps 2; dmireset clears to 0.
REQ-039 With AIRI5C_DTM_HARDRESET_EN, pending read plus dmihardreset -> dmi_req=0 within 1 clk, dmistat=0, late ack ignored.
